width_downsizer: RTL

//  Parametrised N-to-M bus width downsizer (InWidth -> OutWidth, M divides N), second generation of the TTI TX path converter.

---
 rtl/i3c_wconv_pkg.sv | 22 ++
 rtl/width_downsizer.sv | 95 +++++++++
 2 files changed

// File: rtl/i3c_wconv_pkg.sv
// Shared width-conversion helpers for the I3C TTI data path (downsizer now, upsizer later).
// Byte counts of 0 or larger than the word mean "full word".
package i3c_wconv_pkg;

   function automatic int cnt_width(input int beats);
      return $clog2(beats) + 1;
   endfunction

   function automatic int bytes_width(input int word_bits);
      return $clog2(word_bits / 8) + 1;
   endfunction

   function automatic int clamp_bytes(input int bytes, input int word_bytes);
      return ((bytes == 0) || (bytes > word_bytes)) ? word_bytes : bytes;
   endfunction

   function automatic int beats_for_bytes(input int bytes, input int word_bytes,
                                          input int beat_bytes);
      return (clamp_bytes(bytes, word_bytes) + beat_bytes - 1) / beat_bytes;
   endfunction

endpackage

// File: rtl/width_downsizer.sv
// N-to-M width downsizer with partial last word, zero-bubble reload, flush and busy status.
// Optional WIDTH_DOWNSIZER_LAST_EN adds a per-word last flag emitted on the final beat.
module width_downsizer
   import i3c_wconv_pkg::*;
#(
   parameter int InWidth  = 32,
   parameter int OutWidth = 8
) (
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic                               soft_reset_ni,
   input  logic                               sink_valid_i,
   output logic                               sink_ready_o,
   input  logic [InWidth-1:0]                 sink_data_i,
   input  logic [$clog2(InWidth/8):0]         sink_bytes_i,
`ifdef WIDTH_DOWNSIZER_LAST_EN
   input  logic                               sink_last_i,
   output logic                               source_last_o,
`endif
   output logic                               source_valid_o,
   input  logic                               source_ready_i,
   output logic [OutWidth-1:0]                source_data_o,
   input  logic                               source_flush_i,
   output logic                               busy_o
);

   localparam int Beats     = InWidth / OutWidth;
   localparam int BeatBytes = OutWidth / 8;
   localparam int WordBytes = InWidth / 8;
   localparam int CntW      = cnt_width(Beats);

   logic [CntW-1:0]    cnt;
   logic [InWidth-1:0] sreg;
   logic [InWidth-1:0] sink_masked;
   logic [CntW-1:0]    load_cnt;
   logic               accept;
   logic               take;
   int                 n_bytes;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      sink_masked = '0;
      n_bytes     = clamp_bytes(int'(sink_bytes_i), WordBytes);
      for (int i = 0; i < WordBytes; i++) begin
         if (i < n_bytes) sink_masked[i*8 +: 8] = sink_data_i[i*8 +: 8];
      end
      load_cnt = CntW'(beats_for_bytes(int'(sink_bytes_i), WordBytes, BeatBytes));
   end

   // Ready looks through to source_ready_i so the next word loads as the last beat leaves.
   assign sink_ready_o   = !source_flush_i &
                           ((cnt == '0) | ((cnt == CntW'(1)) & source_ready_i));
   assign source_valid_o = (cnt != '0);
   assign busy_o         = source_valid_o;
   assign source_data_o  = sreg[OutWidth-1:0];

   assign accept = sink_valid_i & sink_ready_o;
   assign take   = source_valid_o & source_ready_i;

   // NOTE: sequential state is updated only with non-blocking assignments.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt  <= '0;
         sreg <= '0;
      end else if (!soft_reset_ni || source_flush_i) begin
         cnt  <= '0;
         sreg <= '0;
      end else if (accept) begin
         cnt  <= load_cnt;
         sreg <= sink_masked;
      end else if (take) begin
         cnt  <= cnt - CntW'(1);
         sreg <= sreg >> OutWidth;
      end
   end

`ifdef WIDTH_DOWNSIZER_LAST_EN
   logic last_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_q <= 1'b0;
      end else if (!soft_reset_ni || source_flush_i) begin
         last_q <= 1'b0;
      end else if (accept) begin
         last_q <= sink_last_i;
      end else if (take && (cnt == CntW'(1))) begin
         last_q <= 1'b0;
      end
   end

   assign source_last_o = last_q & (cnt == CntW'(1));
`endif

endmodule
